decode: RTL and testbench
=========================

DECODE -- requirements
Module: decode

Interface
REQ-001 Parameter: data_width, 32, datapath and register width.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-high; ports named clk and rst.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 instr_reg_fetch  input  32  instruction from fetch.
REQ-006 pc_fetch / npc_fetch  input  data_width  PC and next-PC of that instruction.
REQ-007 valid_fetch  input  1  fetch outputs hold a real instruction.
REQ-008 stall_in  input  1  downstream stall; hold decode outputs.
REQ-009 flush_in  input  1  taken branch/jump; squash the instruction being decoded.
REQ-010 wb_en, wb_rd[4:0], wb_data[data_width]  input  writeback port to the register file.
REQ-011 stall_fetch  output  1  fetch must hold its outputs this cycle.
REQ-012 valid_decode  output  1  decode outputs hold a real instruction.
REQ-013 pc_decode, npc_decode, rs1_data_decode, rs2_data_decode, imm_decode  output  data_width each.
REQ-014 rs1_decode, rs2_decode, rd_decode  output  5 each; funct3_decode  output  3; alu_op_decode  output  4.
REQ-015 reg_we_decode, mem_read_decode, mem_write_decode, branch_decode, jump_decode, alu_src_imm_decode, illegal_decode  output  1 each.

Function
REQ-016 All decode outputs are registered; an instruction accepted at edge N appears on the outputs after edge N (latency 1).
REQ-017 Per-edge priority: rst > flush_in > stall_in > load-use bubble > normal accept.
REQ-018 flush_in=1: valid_decode<=0 and all control bits<=0 at the next edge, regardless of stall_in.
REQ-019 stall_in=1 (no flush): every output register holds; stall_fetch=1.
REQ-020 Load-use hazard, combinational: valid_decode & mem_read_decode & rd_decode!=0 & valid_fetch & (rd_decode matches a used rs1 or rs2) -> stall_fetch=1; next edge inserts a bubble (valid_decode<=0, controls<=0); the instruction issues on the following edge.
REQ-021 Immediates for I, S, B, U and J formats are sign-extended to data_width; B/J bit 0 is 0; R-type imm=0.
REQ-022 Register file: 32 x data_width, written at the clock edge when wb_en & wb_rd!=0; x0 always reads 0.
REQ-023 Same-cycle writeback bypass: if wb_en & wb_rd!=0 & wb_rd==rs, the read returns wb_data.
REQ-024 Supported opcodes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP; anything else -> illegal_decode=1, reg_we/mem/branch/jump=0, valid_decode follows valid_fetch.
REQ-025 reg_we_decode=0 whenever rd=0.
REQ-026 valid_fetch=0 at an accept edge loads a bubble (valid_decode=0, controls 0).

Reset
REQ-027 While rst=1: every output and every register-file entry is 0; stall_fetch=0.
REQ-028 Reset asserted mid-hazard or mid-stall discards the pending instruction; after release the first accepted instruction decodes normally.

Structure
REQ-029 Shared package holds opcode constants, the imm-format enum and the alu_op encodings.
REQ-030 One sub-module: regfile (2 async read ports, 1 write port, reset clear, x0 hardwired).

Verification
REQ-031 rst=1 with random inputs -> all outputs 0, stall_fetch=0; release -> outputs remain 0 until the first valid instruction.
REQ-032 0x00500093 (addi x1,x0,5) at pc 0x0 -> next cycle valid=1, rd=1, imm=0x5, reg_we=1, alu_src_imm=1, npc_decode=0x4.
REQ-033 wb_en=1, wb_rd=2, wb_data=0xDEADBEEF in the same cycle as 0x000101B3 (add x3,x2,x0) -> rs1_data_decode=0xDEADBEEF, rs2_data_decode=0.
REQ-034 0x0000A283 (lw x5,0(x1)), then 0x00528333 (add x6,x5,x5) -> stall_fetch=1 for one cycle, one bubble, then add with rd=6.
REQ-035 0xFE000EE3 (beq x0,x0,-4) -> branch=1, imm=0xFFFFFFFC; with flush_in=1 and stall_in=1 on the same edge -> valid_decode=0.
REQ-036 Opcode 0x7F -> illegal_decode=1, reg_we=0, mem_write=0.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared encodings for the decode stage: opcodes, immediate formats,
// ALU operation codes and the immediate extraction helper.
package decode_pkg;

    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_OP     = 7'h33;

    typedef enum logic [2:0] {
        IMM_R,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

    localparam logic [3:0] ALU_ADD    = 4'd0;
    localparam logic [3:0] ALU_SUB    = 4'd1;
    localparam logic [3:0] ALU_SLL    = 4'd2;
    localparam logic [3:0] ALU_SLT    = 4'd3;
    localparam logic [3:0] ALU_SLTU   = 4'd4;
    localparam logic [3:0] ALU_XOR    = 4'd5;
    localparam logic [3:0] ALU_SRL    = 4'd6;
    localparam logic [3:0] ALU_SRA    = 4'd7;
    localparam logic [3:0] ALU_OR     = 4'd8;
    localparam logic [3:0] ALU_AND    = 4'd9;
    localparam logic [3:0] ALU_PASS_B = 4'd10;

    // 32-bit sign-extended immediate; R-type (and illegal) yields zero.
    function automatic logic [31:0] imm_gen(input logic [31:0] instr, input imm_fmt_e fmt);
        case (fmt)
            IMM_I:   imm_gen = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm_gen = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm_gen = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                                instr[11:8], 1'b0};
            IMM_U:   imm_gen = {instr[31:12], 12'b0};
            IMM_J:   imm_gen = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                                instr[30:21], 1'b0};
            default: imm_gen = 32'd0;
        endcase
    endfunction

    // Integer ALU op for OP / OP-IMM. SUB only exists in register form;
    // the shift-right arithmetic select bit is instr[30] in both forms.
    function automatic logic [3:0] arith_op(input logic [2:0] f3, input logic alt,
                                            input logic reg_form);
        case (f3)
            3'd0:    arith_op = (alt && reg_form) ? ALU_SUB : ALU_ADD;
            3'd1:    arith_op = ALU_SLL;
            3'd2:    arith_op = ALU_SLT;
            3'd3:    arith_op = ALU_SLTU;
            3'd4:    arith_op = ALU_XOR;
            3'd5:    arith_op = alt ? ALU_SRA : ALU_SRL;
            3'd6:    arith_op = ALU_OR;
            default: arith_op = ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/decode_regfile.sv
// 32-entry register file: two asynchronous read ports with same-cycle
// writeback bypass, one write port, asynchronous clear, x0 reads as zero.
module decode_regfile #(
    parameter int data_width = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [4:0]            waddr,
    input  logic [data_width-1:0] wdata,
    input  logic [4:0]            raddr1,
    input  logic [4:0]            raddr2,
    output logic [data_width-1:0] rdata1,
    output logic [data_width-1:0] rdata2
);

    logic [data_width-1:0] mem_q [32];
    logic [data_width-1:0] mem_d [32];

    always_comb begin
        mem_d = mem_q;
        if (we && waddr != 5'd0) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // A nonzero address that matches the write port implies the write is real.
    always_comb begin
        rdata1 = '0;
        if (raddr1 != 5'd0) begin
            rdata1 = (we && waddr == raddr1) ? wdata : mem_q[raddr1];
        end
    end

    always_comb begin
        rdata2 = '0;
        if (raddr2 != 5'd0) begin
            rdata2 = (we && waddr == raddr2) ? wdata : mem_q[raddr2];
        end
    end

endmodule

// File: rtl/decode.sv
// Instruction decode stage: field/immediate/control decode, register read,
// load-use bubble insertion and flush/stall handling, all outputs registered.
module decode #(
    parameter int data_width = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           instr_reg_fetch,
    input  logic [data_width-1:0] pc_fetch,
    input  logic [data_width-1:0] npc_fetch,
    input  logic                  valid_fetch,
    input  logic                  stall_in,
    input  logic                  flush_in,
    input  logic                  wb_en,
    input  logic [4:0]            wb_rd,
    input  logic [data_width-1:0] wb_data,
    output logic                  stall_fetch,
    output logic                  valid_decode,
    output logic [data_width-1:0] pc_decode,
    output logic [data_width-1:0] npc_decode,
    output logic [data_width-1:0] rs1_data_decode,
    output logic [data_width-1:0] rs2_data_decode,
    output logic [data_width-1:0] imm_decode,
    output logic [4:0]            rs1_decode,
    output logic [4:0]            rs2_decode,
    output logic [4:0]            rd_decode,
    output logic [2:0]            funct3_decode,
    output logic [3:0]            alu_op_decode,
    output logic                  reg_we_decode,
    output logic                  mem_read_decode,
    output logic                  mem_write_decode,
    output logic                  branch_decode,
    output logic                  jump_decode,
    output logic                  alu_src_imm_decode,
    output logic                  illegal_decode
);

    import decode_pkg::*;

    typedef struct packed {
        logic                  valid;
        logic [data_width-1:0] pc;
        logic [data_width-1:0] npc;
        logic [data_width-1:0] rs1_data;
        logic [data_width-1:0] rs2_data;
        logic [data_width-1:0] imm;
        logic [4:0]            rs1;
        logic [4:0]            rs2;
        logic [4:0]            rd;
        logic [2:0]            funct3;
        logic [3:0]            alu_op;
        logic                  reg_we;
        logic                  mem_read;
        logic                  mem_write;
        logic                  branch;
        logic                  jump;
        logic                  alu_src_imm;
        logic                  illegal;
    } dec_t;

    dec_t                  dec_new;
    dec_t                  dec_d;
    dec_t                  dec_q;
    imm_fmt_e              fmt;
    logic [6:0]            opcode;
    logic [4:0]            rs1_f;
    logic [4:0]            rs2_f;
    logic [4:0]            rd_f;
    logic [2:0]            f3;
    logic                  uses_rs1;
    logic                  uses_rs2;
    logic                  hazard;
    logic [data_width-1:0] rs1_rdata;
    logic [data_width-1:0] rs2_rdata;

    assign opcode = instr_reg_fetch[6:0];
    assign rd_f   = instr_reg_fetch[11:7];
    assign f3     = instr_reg_fetch[14:12];
    assign rs1_f  = instr_reg_fetch[19:15];
    assign rs2_f  = instr_reg_fetch[24:20];

    decode_regfile #(
        .data_width(data_width)
    ) u_regfile (
        .clk    (clk),
        .rst    (rst),
        .we     (wb_en),
        .waddr  (wb_rd),
        .wdata  (wb_data),
        .raddr1 (rs1_f),
        .raddr2 (rs2_f),
        .rdata1 (rs1_rdata),
        .rdata2 (rs2_rdata)
    );

    always_comb begin
        dec_new          = '0;
        fmt              = IMM_R;
        uses_rs1         = 1'b0;
        uses_rs2         = 1'b0;
        dec_new.valid    = 1'b1;
        dec_new.pc       = pc_fetch;
        dec_new.npc      = npc_fetch;
        dec_new.rs1_data = rs1_rdata;
        dec_new.rs2_data = rs2_rdata;
        dec_new.rs1      = rs1_f;
        dec_new.rs2      = rs2_f;
        dec_new.rd       = rd_f;
        dec_new.funct3   = f3;
        dec_new.alu_op   = ALU_ADD;
        case (opcode)
            OPC_LUI: begin
                fmt                 = IMM_U;
                dec_new.reg_we      = 1'b1;
                dec_new.alu_src_imm = 1'b1;
                dec_new.alu_op      = ALU_PASS_B;
            end
            OPC_AUIPC: begin
                fmt                 = IMM_U;
                dec_new.reg_we      = 1'b1;
                dec_new.alu_src_imm = 1'b1;
            end
            OPC_JAL: begin
                fmt                 = IMM_J;
                dec_new.reg_we      = 1'b1;
                dec_new.jump        = 1'b1;
                dec_new.alu_src_imm = 1'b1;
            end
            OPC_JALR: begin
                fmt                 = IMM_I;
                uses_rs1            = 1'b1;
                dec_new.reg_we      = 1'b1;
                dec_new.jump        = 1'b1;
                dec_new.alu_src_imm = 1'b1;
            end
            OPC_BRANCH: begin
                fmt            = IMM_B;
                uses_rs1       = 1'b1;
                uses_rs2       = 1'b1;
                dec_new.branch = 1'b1;
                dec_new.alu_op = ALU_SUB;
            end
            OPC_LOAD: begin
                fmt                 = IMM_I;
                uses_rs1            = 1'b1;
                dec_new.reg_we      = 1'b1;
                dec_new.mem_read    = 1'b1;
                dec_new.alu_src_imm = 1'b1;
            end
            OPC_STORE: begin
                fmt                 = IMM_S;
                uses_rs1            = 1'b1;
                uses_rs2            = 1'b1;
                dec_new.mem_write   = 1'b1;
                dec_new.alu_src_imm = 1'b1;
            end
            OPC_OP_IMM: begin
                fmt                 = IMM_I;
                uses_rs1            = 1'b1;
                dec_new.reg_we      = 1'b1;
                dec_new.alu_src_imm = 1'b1;
                dec_new.alu_op      = arith_op(f3, instr_reg_fetch[30], 1'b0);
            end
            OPC_OP: begin
                uses_rs1       = 1'b1;
                uses_rs2       = 1'b1;
                dec_new.reg_we = 1'b1;
                dec_new.alu_op = arith_op(f3, instr_reg_fetch[30], 1'b1);
            end
            default: begin
                dec_new.illegal = 1'b1;
            end
        endcase
        dec_new.imm = data_width'($signed(imm_gen(instr_reg_fetch, fmt)));
        if (rd_f == 5'd0) begin
            dec_new.reg_we = 1'b0;
        end
    end

    // A load sitting in decode whose destination the fetched instruction reads.
    assign hazard = dec_q.valid && dec_q.mem_read && (dec_q.rd != 5'd0) && valid_fetch &&
                    ((uses_rs1 && rs1_f == dec_q.rd) || (uses_rs2 && rs2_f == dec_q.rd));

    always_comb begin
        dec_d = dec_q;
        if (flush_in) begin
            dec_d = '0;
        end else if (stall_in) begin
            dec_d = dec_q;
        end else if (hazard) begin
            dec_d = '0;
        end else if (!valid_fetch) begin
            dec_d = '0;
        end else begin
            dec_d = dec_new;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_q <= '0;
        end else begin
            dec_q <= dec_d;
        end
    end

    // Fetch/decode handshake: the fetched instruction is consumed at an edge
    // only when stall_fetch is low that cycle; otherwise fetch must present
    // the same instruction again. A flush redirects fetch, so no hold then.
    assign stall_fetch = !rst && !flush_in && (stall_in || hazard);

    assign valid_decode       = dec_q.valid;
    assign pc_decode          = dec_q.pc;
    assign npc_decode         = dec_q.npc;
    assign rs1_data_decode    = dec_q.rs1_data;
    assign rs2_data_decode    = dec_q.rs2_data;
    assign imm_decode         = dec_q.imm;
    assign rs1_decode         = dec_q.rs1;
    assign rs2_decode         = dec_q.rs2;
    assign rd_decode          = dec_q.rd;
    assign funct3_decode      = dec_q.funct3;
    assign alu_op_decode      = dec_q.alu_op;
    assign reg_we_decode      = dec_q.reg_we;
    assign mem_read_decode    = dec_q.mem_read;
    assign mem_write_decode   = dec_q.mem_write;
    assign branch_decode      = dec_q.branch;
    assign jump_decode        = dec_q.jump;
    assign alu_src_imm_decode = dec_q.alu_src_imm;
    assign illegal_decode     = dec_q.illegal;

endmodule

// File: tb/tb_decode.sv
// Bench for the decode stage: directed scenarios plus randomized traffic
// checked against an instruction-level reference model.
`timescale 1ns/1ps
module tb_decode;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   instr_reg_fetch;
    logic [DW-1:0] pc_fetch;
    logic [DW-1:0] npc_fetch;
    logic          valid_fetch;
    logic          stall_in;
    logic          flush_in;
    logic          wb_en;
    logic [4:0]    wb_rd;
    logic [DW-1:0] wb_data;
    logic          stall_fetch;
    logic          valid_decode;
    logic [DW-1:0] pc_decode, npc_decode, rs1_data_decode, rs2_data_decode, imm_decode;
    logic [4:0]    rs1_decode, rs2_decode, rd_decode;
    logic [2:0]    funct3_decode;
    logic [3:0]    alu_op_decode;
    logic          reg_we_decode, mem_read_decode, mem_write_decode, branch_decode;
    logic          jump_decode, alu_src_imm_decode, illegal_decode;

    decode #(.data_width(DW)) dut (
        .clk                (clk),
        .rst                (rst),
        .instr_reg_fetch    (instr_reg_fetch),
        .pc_fetch           (pc_fetch),
        .npc_fetch          (npc_fetch),
        .valid_fetch        (valid_fetch),
        .stall_in           (stall_in),
        .flush_in           (flush_in),
        .wb_en              (wb_en),
        .wb_rd              (wb_rd),
        .wb_data            (wb_data),
        .stall_fetch        (stall_fetch),
        .valid_decode       (valid_decode),
        .pc_decode          (pc_decode),
        .npc_decode         (npc_decode),
        .rs1_data_decode    (rs1_data_decode),
        .rs2_data_decode    (rs2_data_decode),
        .imm_decode         (imm_decode),
        .rs1_decode         (rs1_decode),
        .rs2_decode         (rs2_decode),
        .rd_decode          (rd_decode),
        .funct3_decode      (funct3_decode),
        .alu_op_decode      (alu_op_decode),
        .reg_we_decode      (reg_we_decode),
        .mem_read_decode    (mem_read_decode),
        .mem_write_decode   (mem_write_decode),
        .branch_decode      (branch_decode),
        .jump_decode        (jump_decode),
        .alu_src_imm_decode (alu_src_imm_decode),
        .illegal_decode     (illegal_decode)
    );

    // clock / reset
    always #5 clk = ~clk;

    typedef struct packed {
        logic          valid;
        logic [DW-1:0] pc, npc, rs1_data, rs2_data, imm;
        logic [4:0]    rs1, rs2, rd;
        logic [2:0]    funct3;
        logic [3:0]    alu_op;
        logic          reg_we, mem_read, mem_write, branch, jump, alu_src_imm, illegal;
    } dec_t;

    dec_t        obs;
    dec_t        exp_s;
    logic [31:0] m_rf [32];
    int          n_cmp = 0;
    int          n_err = 0;

    always_comb begin
        obs = '{valid_decode, pc_decode, npc_decode, rs1_data_decode, rs2_data_decode,
                imm_decode, rs1_decode, rs2_decode, rd_decode, funct3_decode, alu_op_decode,
                reg_we_decode, mem_read_decode, mem_write_decode, branch_decode, jump_decode,
                alu_src_imm_decode, illegal_decode};
    end

    // reference model
    function automatic logic m_uses_rs1(input logic [6:0] op);
        return op inside {7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
    endfunction

    function automatic logic m_uses_rs2(input logic [6:0] op);
        return op inside {7'h63, 7'h23, 7'h33};
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] r);
        if (r == 5'd0) return 32'd0;
        if (wb_en && wb_rd == r) return wb_data;
        return m_rf[r];
    endfunction

    function automatic logic m_hazard();
        logic [31:0] ins;
        ins = instr_reg_fetch;
        return exp_s.valid && exp_s.mem_read && exp_s.rd != 5'd0 && valid_fetch &&
               ((m_uses_rs1(ins[6:0]) && ins[19:15] == exp_s.rd) ||
                (m_uses_rs2(ins[6:0]) && ins[24:20] == exp_s.rd));
    endfunction

    function automatic logic exp_stall();
        return !rst && !flush_in && (stall_in || m_hazard());
    endfunction

    function automatic dec_t m_decode(input logic [31:0] ins, input logic [31:0] pc,
                                      input logic [31:0] npc, input logic [31:0] a,
                                      input logic [31:0] b);
        dec_t       d;
        logic [3:0] tab [8];
        int         sgn, imm_i, imm_s, imm_b, imm_j;
        int         f3;
        tab   = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
        f3    = int'(ins[14:12]);
        sgn   = int'(ins[31]);
        imm_i = int'(ins[31:20]) - sgn * 4096;
        imm_s = int'(ins[31:25]) * 32 + int'(ins[11:7]) - sgn * 4096;
        imm_b = int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2 - sgn * 4096;
        imm_j = int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2
                - sgn * 1048576;
        d          = '0;
        d.valid    = 1'b1;
        d.pc       = pc;
        d.npc      = npc;
        d.rs1_data = a;
        d.rs2_data = b;
        d.rs1      = ins[19:15];
        d.rs2      = ins[24:20];
        d.rd       = ins[11:7];
        d.funct3   = ins[14:12];
        case (ins[6:0])
            7'h37: begin d.imm = ins & 32'hFFFFF000; d.alu_op = 4'd10; d.reg_we = 1; d.alu_src_imm = 1; end
            7'h17: begin d.imm = ins & 32'hFFFFF000; d.reg_we = 1; d.alu_src_imm = 1; end
            7'h6F: begin d.imm = 32'(imm_j); d.reg_we = 1; d.jump = 1; d.alu_src_imm = 1; end
            7'h67: begin d.imm = 32'(imm_i); d.reg_we = 1; d.jump = 1; d.alu_src_imm = 1; end
            7'h63: begin d.imm = 32'(imm_b); d.branch = 1; d.alu_op = 4'd1; end
            7'h03: begin d.imm = 32'(imm_i); d.reg_we = 1; d.mem_read = 1; d.alu_src_imm = 1; end
            7'h23: begin d.imm = 32'(imm_s); d.mem_write = 1; d.alu_src_imm = 1; end
            7'h13: begin
                d.imm = 32'(imm_i); d.reg_we = 1; d.alu_src_imm = 1; d.alu_op = tab[f3];
                if (f3 == 5 && ins[30]) d.alu_op = 4'd7;
            end
            7'h33: begin
                d.reg_we = 1; d.alu_op = tab[f3];
                if (f3 == 0 && ins[30]) d.alu_op = 4'd1;
                if (f3 == 5 && ins[30]) d.alu_op = 4'd7;
            end
            default: d.illegal = 1;
        endcase
        if (d.rd == 5'd0) d.reg_we = 1'b0;
        return d;
    endfunction

    task automatic model_clear();
        exp_s = '0;
        for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    endtask

    // Advance the model across the coming edge using the inputs now applied.
    task automatic model_edge();
        dec_t n;
        if (rst) begin
            model_clear();
            return;
        end
        if (flush_in) n = '0;
        else if (stall_in) n = exp_s;
        else if (m_hazard()) n = '0;
        else if (!valid_fetch) n = '0;
        else n = m_decode(instr_reg_fetch, pc_fetch, npc_fetch,
                          m_read(instr_reg_fetch[19:15]), m_read(instr_reg_fetch[24:20]));
        if (wb_en && wb_rd != 5'd0) m_rf[wb_rd] = wb_data;
        exp_s = n;
    endtask

    // driver tasks
    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        valid_fetch = 1'b0;
        stall_in    = 1'b0;
        flush_in    = 1'b0;
        wb_en       = 1'b0;
        wb_rd       = 5'd0;
        wb_data     = 32'd0;
    endtask

    task automatic fetch(input logic [31:0] ins, input logic [31:0] pc);
        instr_reg_fetch = ins;
        pc_fetch        = pc;
        npc_fetch       = pc + 32'd4;
        valid_fetch     = 1'b1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        logic [6:0]  op;
        ins = $urandom;
        case ($urandom_range(0, 11))
            0, 1, 2: op = 7'h03;
            3:       op = 7'h37;
            4:       op = 7'h17;
            5:       op = 7'h6F;
            6:       op = 7'h67;
            7:       op = 7'h63;
            8:       op = 7'h23;
            9:       op = 7'h13;
            10:      op = 7'h33;
            default: op = 7'h7F;
        endcase
        ins[6:0]   = op;
        ins[11:7]  = 5'($urandom_range(0, 3));
        ins[19:15] = 5'($urandom_range(0, 3));
        ins[24:20] = 5'($urandom_range(0, 3));
        return ins;
    endfunction

    // scenarios
    task automatic test_reset();
        rst = 1'b1;
        model_clear();
        for (int i = 0; i < 4; i++) begin
            fetch($urandom, $urandom);
            stall_in = (i % 2 == 0);
            flush_in = 1'b0;
            wb_en    = 1'b1;
            wb_rd    = 5'($urandom_range(1, 31));
            wb_data  = $urandom;
            #1;
            n_cmp++;
            if (obs !== '0 || stall_fetch !== 1'b0) begin
                n_err++;
                $display("FAIL reset_hold got %h stall %b want 0 stall 0", obs, stall_fetch);
            end
            tick();
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            instr_reg_fetch = $urandom;
            valid_fetch     = 1'b0;
            stall_in        = 1'(i == 1);
            wb_en           = 1'b0;
            tick();
            n_cmp++;
            if (obs !== '0) begin
                n_err++;
                $display("FAIL reset_release got %h want 0", obs);
            end
        end
        idle();
    endtask

    task automatic test_addi();
        fetch(32'h00500093, 32'h0);
        tick();
        n_cmp++;
        if (obs !== exp_s || valid_decode !== 1'b1 || rd_decode !== 5'd1 ||
            imm_decode !== 32'h5 || reg_we_decode !== 1'b1 || alu_src_imm_decode !== 1'b1 ||
            npc_decode !== 32'h4) begin
            n_err++;
            $display("FAIL addi got %h want %h", obs, exp_s);
        end
        idle();
    endtask

    task automatic test_bypass();
        fetch(32'h000101B3, 32'h100);
        wb_en   = 1'b1;
        wb_rd   = 5'd2;
        wb_data = 32'hDEADBEEF;
        tick();
        n_cmp++;
        if (rs1_data_decode !== 32'hDEADBEEF || rs2_data_decode !== 32'h0 || obs !== exp_s) begin
            n_err++;
            $display("FAIL bypass got rs1 %h rs2 %h want deadbeef 0", rs1_data_decode,
                     rs2_data_decode);
        end
        idle();
    endtask

    task automatic test_load_use();
        fetch(32'h0000A283, 32'h200);
        tick();
        fetch(32'h00528333, 32'h204);
        #1;
        n_cmp++;
        if (stall_fetch !== 1'b1) begin
            n_err++;
            $display("FAIL load_use_stall got %b want 1", stall_fetch);
        end
        tick();
        n_cmp++;
        if (valid_decode !== 1'b0 || mem_read_decode !== 1'b0 || stall_fetch !== 1'b0) begin
            n_err++;
            $display("FAIL load_use_bubble got valid %b stall %b want 0 0", valid_decode,
                     stall_fetch);
        end
        tick();
        n_cmp++;
        if (valid_decode !== 1'b1 || rd_decode !== 5'd6 || obs !== exp_s) begin
            n_err++;
            $display("FAIL load_use_issue got %h want %h", obs, exp_s);
        end
        idle();
    endtask

    task automatic test_branch_stall_flush();
        fetch(32'hFE000EE3, 32'h300);
        tick();
        n_cmp++;
        if (branch_decode !== 1'b1 || imm_decode !== 32'hFFFFFFFC || obs !== exp_s) begin
            n_err++;
            $display("FAIL branch got branch %b imm %h want 1 fffffffc", branch_decode,
                     imm_decode);
        end
        fetch(32'h00500093, 32'h304);
        stall_in = 1'b1;
        #1;
        n_cmp++;
        if (stall_fetch !== 1'b1) begin
            n_err++;
            $display("FAIL stall_fetch got %b want 1", stall_fetch);
        end
        tick();
        tick();
        n_cmp++;
        if (branch_decode !== 1'b1 || pc_decode !== 32'h300 || obs !== exp_s) begin
            n_err++;
            $display("FAIL stall_hold got %h want %h", obs, exp_s);
        end
        flush_in = 1'b1;
        tick();
        n_cmp++;
        if (valid_decode !== 1'b0 || branch_decode !== 1'b0 || obs !== exp_s) begin
            n_err++;
            $display("FAIL flush got valid %b branch %b want 0 0", valid_decode, branch_decode);
        end
        idle();
    endtask

    task automatic test_illegal();
        fetch(32'h000000FF, 32'h400);
        tick();
        n_cmp++;
        if (illegal_decode !== 1'b1 || reg_we_decode !== 1'b0 || mem_write_decode !== 1'b0 ||
            valid_decode !== 1'b1 || obs !== exp_s) begin
            n_err++;
            $display("FAIL illegal got %h want %h", obs, exp_s);
        end
        valid_fetch = 1'b0;
        tick();
        n_cmp++;
        if (valid_decode !== 1'b0 || illegal_decode !== 1'b0) begin
            n_err++;
            $display("FAIL invalid_fetch got valid %b illegal %b want 0 0", valid_decode,
                     illegal_decode);
        end
        idle();
    endtask

    task automatic test_reset_mid_hazard();
        wb_en   = 1'b1;
        wb_rd   = 5'd5;
        wb_data = 32'h12345678;
        tick();
        wb_en = 1'b0;
        fetch(32'h0000A283, 32'h500);
        tick();
        fetch(32'h00528333, 32'h504);
        #1;
        rst = 1'b1;
        model_clear();
        #1;
        n_cmp++;
        if (obs !== '0 || stall_fetch !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid got %h stall %b want 0 0", obs, stall_fetch);
        end
        tick();
        rst = 1'b0;
        tick();
        n_cmp++;
        if (valid_decode !== 1'b1 || rd_decode !== 5'd6 || rs1_data_decode !== 32'h0 ||
            obs !== exp_s) begin
            n_err++;
            $display("FAIL reset_mid_issue got %h want %h", obs, exp_s);
        end
        idle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rst = 1'($urandom_range(0, 99) == 0);
            if (rst) model_clear();
            fetch(rand_instr(), $urandom & 32'hFFFFFFFC);
            valid_fetch = 1'($urandom_range(0, 9) != 0);
            stall_in    = 1'($urandom_range(0, 7) == 0);
            flush_in    = 1'($urandom_range(0, 11) == 0);
            wb_en       = 1'($urandom_range(0, 1));
            wb_rd       = 5'($urandom_range(0, 3));
            wb_data     = $urandom;
            #1;
            n_cmp++;
            if (stall_fetch !== exp_stall()) begin
                n_err++;
                $display("FAIL rand_stall_fetch cycle %0d got %b want %b", i, stall_fetch,
                         exp_stall());
            end
            tick();
            n_cmp++;
            if (obs !== exp_s) begin
                n_err++;
                $display("FAIL rand_outputs cycle %0d got %h want %h", i, obs, exp_s);
            end
        end
        rst = 1'b0;
        idle();
    endtask

    initial begin
        rst = 1'b1;
        instr_reg_fetch = 32'd0;
        pc_fetch = 32'd0;
        npc_fetch = 32'd0;
        idle();
        model_clear();
        test_reset();
        test_addi();
        test_bypass();
        test_load_use();
        test_branch_stall_flush();
        test_illegal();
        test_reset_mid_hazard();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
